icache: RTL and testbench
=========================

Name: icache

Overview:
- Instruction-side cache and responder for the fetch unit's `icache_enable`/`pc_to_fetch` request interface.
- Direct-mapped with one 32-bit word per line.
- Returns hits with one-cycle latency.
- Services misses through a single-word read request to the memory controller.
- Sits between the fetch unit and the memory controller's instruction port; supports flush on branch mispredict (`jump_wrong`).

Parameters:
- `LINES`, 256, number of cache lines (power of two, ≥2).
- `INDEX_W`, 8, log2(`LINES`).
- `TAG_W`, 22, equals 32-2-`INDEX_W`.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `rdy`  in  1  global ready; 0 freezes all state.
- `jump_wrong`  in  1  mispredict flush from ROB.
- `icache_enable`  in  1  fetch request valid (level; held until success).
- `pc_to_fetch`  in  32  fetch address; bits [1:0] ignored.
- `instr_fetched`  out  32  instruction word; valid when `icache_success`=1.
- `icache_success`  out  1  one-cycle response pulse.
- `mem_req`  out  1  word read request to memory controller (level until done).
- `mem_addr`  out  32  word-aligned read address.
- `mem_data`  in  32  read data, valid with `mem_done`.
- `mem_done`  in  1  one-cycle completion pulse from memory controller.

Behaviour:
- Reset (async, `rst`=1):
  - All valid bits cleared; state=IDLE.
  - `icache_success`=0, `instr_fetched`=0, `mem_req`=0, `mem_addr`=0, drop flag=0.
- `rdy`=0: no state, array or output register changes. Inputs are ignored that cycle, including a `mem_done` pulse; the memory controller is frozen by the same `rdy`.
- Address split: index=`pc`[`INDEX_W`+1:2], tag=`pc`[31:`INDEX_W`+2].
- FSM states: IDLE, MISS, GAP.
- IDLE:
  - A request is accepted at a posedge where `icache_enable`=1 and `jump_wrong`=0.
  - Hit (line valid and tag equal): `instr_fetched`<=line data, `icache_success`<=1; go to GAP. Latency is one cycle: the pulse is high for the cycle after the acceptance edge.
  - Miss: latch `pc`; `mem_req`<=1, `mem_addr`<={`pc`[31:2],2'b00}; go to MISS.
- MISS:
  - Hold `mem_req`/`mem_addr` until the edge where `mem_done`=1.
  - On that edge: write data, tag and valid into the line; `mem_req`<=0.
  - If drop flag=0: `instr_fetched`<=`mem_data`, `icache_success`<=1, go to GAP.
  - If drop flag=1: clear drop flag, no success pulse, go to IDLE.
- GAP:
  - `icache_success`<=0.
  - `icache_enable` is ignored for this one cycle, so the fetch unit's still-high enable is not re-served; then go to IDLE.
- `icache_success` is never high for two consecutive cycles.
- `jump_wrong`=1 at a posedge:
  - `icache_success`<=0, overriding any hit/fill response at that edge.
  - In MISS (and `mem_done` not on this edge): set drop flag. The memory transaction is never aborted; the fill still completes and updates the array.
  - `mem_done` and `jump_wrong` on the same edge: fill the line, suppress the response, go to IDLE.
  - In IDLE: no request is accepted this edge. The redirected request is accepted at the next edge with `jump_wrong`=0.
  - In GAP: proceed to IDLE.
- Reset mid-miss: state cleared immediately. The memory controller is reset by the same `rst`, so no stale `mem_done` can arrive.
- No write/invalidate path; self-modifying code is unsupported.
- A `mem_done` outside MISS is ignored.

Decomposition:
- Shared `define.v` additions:
  - `ICACHE_LINES`, `ICACHE_INDEX`, `ICACHE_TAG` range macros.
  - State encodings `IC_IDLE`, `IC_MISS`, `IC_GAP`.
  - Reuse existing `ADDR`, `INSTRLEN`, `TRUE`/`FALSE`.
- One natural sub-module: `icache_array`.
  - Valid, tag and data storage with combinational read and a synchronous write port.
  - Valid bits are async-cleared on `rst`.
- The FSM and handshake logic stay in `icache`.

Test Plan:
1. Cold miss: reset, `icache_enable`=1, `pc_to_fetch`=0x00000000; memory returns `mem_done` with 0x00000513 three cycles later. Required: `mem_req`=1 with `mem_addr`=0x0 until done; `icache_success`=1 for exactly one cycle with `instr_fetched`=0x00000513; no second request during GAP.
2. Hit: after scenario 1, request 0x00000000 again. Required: `icache_success` the cycle after acceptance, data 0x00000513, `mem_req` stays 0.
3. Conflict eviction (`LINES`=256): fill 0x00000004, then request 0x00000404 (same index, different tag). Required: miss, `mem_addr`=0x00000404, line replaced; a later request to 0x00000004 misses again.
4. Flush mid-miss: miss on 0x00001000, pulse `jump_wrong` two cycles before `mem_done`, then request 0x00000008 (cached). Required:
   - No success for 0x1000.
   - The 0x1000 line is filled; a later request to 0x1000 hits.
   - 0x8 is served only after the MISS state completes.
5. Simultaneous `mem_done` and `jump_wrong` on the same edge: required no `icache_success`, line written, FSM in IDLE next cycle.
6. `rdy` low: deassert `rdy` for 5 cycles while in MISS with `mem_done` absent. Required: `mem_req`/`mem_addr` held, no output changes. Reassert `rdy`, then complete normally; async `rst` mid-MISS returns all outputs to 0 without waiting for a clock edge.

Source files
------------

// File: rtl/icache_pkg.sv
// rtl/icache_pkg.sv - shared sizes, FSM encoding and address helpers for the instruction cache
package icache_pkg;

  localparam int ICACHE_LINES = 256;
  localparam int ICACHE_INDEX = 8;
  localparam int ICACHE_TAG   = 32 - 2 - ICACHE_INDEX;
  localparam int ADDR_W       = 32;
  localparam int INSTR_W      = 32;

  typedef enum logic [1:0] {
    IC_IDLE = 2'd0,
    IC_MISS = 2'd1,
    IC_GAP  = 2'd2
  } ic_state_e;

  // Byte address of the word containing pc; the memory port only reads whole words
  function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] pc);
    return {pc[ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/icache_array.sv
// rtl/icache_array.sv - direct-mapped valid/tag/data store, async read, sync write
module icache_array
  import icache_pkg::*;
#(
  parameter int LINES   = ICACHE_LINES,
  parameter int INDEX_W = ICACHE_INDEX,
  parameter int TAG_W   = ICACHE_TAG
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [INDEX_W-1:0] rd_index,
  output logic               rd_valid,
  output logic [TAG_W-1:0]   rd_tag,
  output logic [31:0]        rd_data,
  input  logic               wr_en,
  input  logic [INDEX_W-1:0] wr_index,
  input  logic [TAG_W-1:0]   wr_tag,
  input  logic [31:0]        wr_data
);

  logic [LINES-1:0] valid_q;
  logic [LINES-1:0] valid_d;
  logic [TAG_W-1:0] tag_mem  [LINES];
  logic [31:0]      data_mem [LINES];

  // A fill marks its line valid; nothing ever invalidates a single line
  always_comb begin
    valid_d = valid_q;
    if (wr_en) valid_d[wr_index] = 1'b1;
  end

  // Valid bits are the only state that must be cleared by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) valid_q <= '0;
    else     valid_q <= valid_d;
  end

  // Tag and data storage carry no reset; they are meaningless until the valid bit is set
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_mem[wr_index]  <= wr_tag;
      data_mem[wr_index] <= wr_data;
    end
  end

  assign rd_valid = valid_q[rd_index];
  assign rd_tag   = tag_mem[rd_index];
  assign rd_data  = data_mem[rd_index];

endmodule

// File: rtl/icache.sv
// rtl/icache.sv - direct-mapped instruction cache with single-word miss fill and mispredict drop
module icache
  import icache_pkg::*;
#(
  parameter int LINES   = ICACHE_LINES,
  parameter int INDEX_W = ICACHE_INDEX,
  parameter int TAG_W   = ICACHE_TAG
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        jump_wrong,
  input  logic        icache_enable,
  input  logic [31:0] pc_to_fetch,
  output logic [31:0] instr_fetched,
  output logic        icache_success,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_data,
  input  logic        mem_done
);

  ic_state_e   state_q, state_d;
  logic [31:0] instr_q, instr_d;
  logic        success_q, success_d;
  logic        mem_req_q, mem_req_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic        drop_q, drop_d;

  logic               rd_valid;
  logic [TAG_W-1:0]   rd_tag;
  logic [31:0]        rd_data;
  logic               hit;
  logic               wr_en;
  logic               unused_pc_bits;

  // Byte-offset bits of the fetch address never select anything
  assign unused_pc_bits = ^pc_to_fetch[1:0];

  icache_array #(
    .LINES  (LINES),
    .INDEX_W(INDEX_W),
    .TAG_W  (TAG_W)
  ) u_array (
    .clk     (clk),
    .rst     (rst),
    .rd_index(pc_to_fetch[INDEX_W+1:2]),
    .rd_valid(rd_valid),
    .rd_tag  (rd_tag),
    .rd_data (rd_data),
    .wr_en   (wr_en),
    .wr_index(mem_addr_q[INDEX_W+1:2]),
    .wr_tag  (mem_addr_q[31:INDEX_W+2]),
    .wr_data (mem_data)
  );

  assign hit = rd_valid && (rd_tag == pc_to_fetch[31:INDEX_W+2]);

  // Fill the line on the completing edge of a miss, whether or not the response is dropped
  assign wr_en = rdy && (state_q == IC_MISS) && mem_done;

  // Next-state and response logic; with rdy low everything holds its value
  always_comb begin
    state_d    = state_q;
    instr_d    = instr_q;
    success_d  = success_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    drop_d     = drop_q;
    if (rdy) begin
      success_d = 1'b0;
      unique case (state_q)
        IC_IDLE: begin
          if (icache_enable && !jump_wrong) begin
            if (hit) begin
              instr_d   = rd_data;
              success_d = 1'b1;
              state_d   = IC_GAP;
            end else begin
              mem_req_d  = 1'b1;
              mem_addr_d = word_align(pc_to_fetch);
              state_d    = IC_MISS;
            end
          end
        end
        IC_MISS: begin
          if (mem_done) begin
            mem_req_d = 1'b0;
            if (drop_q || jump_wrong) begin
              drop_d  = 1'b0;
              state_d = IC_IDLE;
            end else begin
              instr_d   = mem_data;
              success_d = 1'b1;
              state_d   = IC_GAP;
            end
          end else if (jump_wrong) begin
            drop_d = 1'b1;
          end
        end
        IC_GAP: begin
          // The fetch unit still holds enable this cycle; skip it so it is not served twice
          state_d = IC_IDLE;
        end
        default: state_d = IC_IDLE;
      endcase
    end
  end

  // FSM state and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IC_IDLE;
      instr_q    <= '0;
      success_q  <= 1'b0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      drop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      instr_q    <= instr_d;
      success_q  <= success_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      drop_q     <= drop_d;
    end
  end

  assign instr_fetched  = instr_q;
  assign icache_success = success_q;
  assign mem_req        = mem_req_q;
  assign mem_addr       = mem_addr_q;

endmodule

// File: tb/tb_icache.sv
// tb/tb_icache.sv - scoreboard bench for the instruction cache
`timescale 1ns/1ps
module tb_icache;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rdy = 1'b1;
  logic        jump_wrong = 1'b0;
  logic        icache_enable = 1'b0;
  logic [31:0] pc_to_fetch = '0;
  logic [31:0] instr_fetched;
  logic        icache_success;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_data = '0;
  logic        mem_done = 1'b0;

  int pass_cnt = 0;
  int total_cnt = 0;
  logic [31:0] exp_q[$];
  logic prev_success = 1'b0;

  always #5 clk = ~clk;

  icache dut (
    .clk           (clk),
    .rst           (rst),
    .rdy           (rdy),
    .jump_wrong    (jump_wrong),
    .icache_enable (icache_enable),
    .pc_to_fetch   (pc_to_fetch),
    .instr_fetched (instr_fetched),
    .icache_success(icache_success),
    .mem_req       (mem_req),
    .mem_addr      (mem_addr),
    .mem_data      (mem_data),
    .mem_done      (mem_done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h required %h", name, act, exp);
  endtask

  // Monitor: every response pulse pops the oldest expected instruction
  always @(negedge clk) begin
    if (!rst && icache_success) begin
      check("no_back_to_back", {31'd0, prev_success}, 32'd0);
      if (exp_q.size() == 0) begin
        total_cnt++;
        $display("FAIL sb_unexpected: got %h required no response", instr_fetched);
      end else begin
        check("sb_data", instr_fetched, exp_q.pop_front());
      end
    end
    prev_success = rst ? 1'b0 : icache_success;
  end

  task automatic wait_req();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mem_req) break;
    end
    check("req_seen", {31'd0, mem_req}, 32'd1);
  endtask

  task automatic gap_check();
    @(posedge clk); #1 icache_enable = 1'b0;
    @(negedge clk);
    check("gap_no_success", {31'd0, icache_success}, 32'd0);
    check("gap_no_req", {31'd0, mem_req}, 32'd0);
  endtask

  task automatic fetch_miss(input logic [31:0] pc, input logic [31:0] data, input int delay);
    @(posedge clk); #1;
    pc_to_fetch = pc; icache_enable = 1'b1;
    exp_q.push_back(data);
    wait_req();
    check("miss_addr", mem_addr, {pc[31:2], 2'b00});
    repeat (delay) @(posedge clk);
    #1 mem_done = 1'b1; mem_data = data;
    check("req_held", {31'd0, mem_req}, 32'd1);
    @(posedge clk); #1 mem_done = 1'b0; mem_data = '0;
    @(negedge clk);
    check("fill_resp", {31'd0, icache_success}, 32'd1);
    check("req_dropped", {31'd0, mem_req}, 32'd0);
    gap_check();
  endtask

  task automatic fetch_hit(input logic [31:0] pc, input logic [31:0] data);
    @(posedge clk); #1;
    pc_to_fetch = pc; icache_enable = 1'b1;
    exp_q.push_back(data);
    @(posedge clk);
    @(negedge clk);
    check("hit_latency", {31'd0, icache_success}, 32'd1);
    check("hit_no_req", {31'd0, mem_req}, 32'd0);
    gap_check();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_success", {31'd0, icache_success}, 32'd0);
    check("rst_instr", instr_fetched, 32'd0);
    check("rst_req", {31'd0, mem_req}, 32'd0);
    check("rst_addr", mem_addr, 32'd0);
    rst = 1'b0;

    // Cold miss, then hit
    fetch_miss(32'h0000_0000, 32'h0000_0513, 3);
    fetch_hit(32'h0000_0000, 32'h0000_0513);

    // Conflict eviction on index 1
    fetch_miss(32'h0000_0004, 32'h00a0_0093, 2);
    fetch_miss(32'h0000_0404, 32'h00b0_0113, 1);
    fetch_miss(32'h0000_0004, 32'h00a0_0093, 2);

    // Flush mid-miss, redirected fetch of a cached line
    fetch_miss(32'h0000_0008, 32'h0010_0113, 2);
    @(posedge clk); #1;
    pc_to_fetch = 32'h0000_1000; icache_enable = 1'b1;
    wait_req();
    check("flush_addr", mem_addr, 32'h0000_1000);
    @(posedge clk); #1;
    jump_wrong = 1'b1; pc_to_fetch = 32'h0000_0008;
    exp_q.push_back(32'h0010_0113);
    @(posedge clk); #1 jump_wrong = 1'b0;
    @(posedge clk); #1 mem_done = 1'b1; mem_data = 32'h1234_5678;
    @(posedge clk); #1 mem_done = 1'b0; mem_data = '0;
    @(negedge clk);
    check("flush_no_resp", {31'd0, icache_success}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("redirect_hit", {31'd0, icache_success}, 32'd1);
    gap_check();
    fetch_hit(32'h0000_1000, 32'h1234_5678);

    // mem_done and jump_wrong on the same edge
    @(posedge clk); #1;
    pc_to_fetch = 32'h0000_2000; icache_enable = 1'b1;
    wait_req();
    @(posedge clk); #1;
    mem_done = 1'b1; mem_data = 32'h0bad_cafe; jump_wrong = 1'b1; icache_enable = 1'b0;
    @(posedge clk); #1;
    mem_done = 1'b0; mem_data = '0; jump_wrong = 1'b0; icache_enable = 1'b1;
    exp_q.push_back(32'h0bad_cafe);
    @(negedge clk);
    check("same_edge_no_resp", {31'd0, icache_success}, 32'd0);
    check("same_edge_req_off", {31'd0, mem_req}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("idle_after_same_edge", {31'd0, icache_success}, 32'd1);
    gap_check();

    // rdy freeze mid-miss, including a mem_done pulse that must be ignored
    @(posedge clk); #1;
    pc_to_fetch = 32'h0000_3000; icache_enable = 1'b1;
    exp_q.push_back(32'h0030_0093);
    wait_req();
    @(posedge clk); #1 rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("frz_req", {31'd0, mem_req}, 32'd1);
      check("frz_addr", mem_addr, 32'h0000_3000);
      check("frz_success", {31'd0, icache_success}, 32'd0);
      check("frz_instr", instr_fetched, 32'h0bad_cafe);
      if (i == 1) begin mem_done = 1'b1; mem_data = 32'hdead_beef; end
      if (i == 2) begin mem_done = 1'b0; mem_data = '0; end
    end
    @(posedge clk); #1 rdy = 1'b1;
    @(posedge clk); #1 mem_done = 1'b1; mem_data = 32'h0030_0093;
    @(posedge clk); #1 mem_done = 1'b0; mem_data = '0;
    @(negedge clk);
    check("thaw_resp", {31'd0, icache_success}, 32'd1);
    gap_check();

    // Async reset in the middle of a miss
    @(posedge clk); #1;
    pc_to_fetch = 32'h0000_4000; icache_enable = 1'b1;
    wait_req();
    #2 rst = 1'b1;
    #1;
    check("arst_req", {31'd0, mem_req}, 32'd0);
    check("arst_addr", mem_addr, 32'd0);
    check("arst_success", {31'd0, icache_success}, 32'd0);
    check("arst_instr", instr_fetched, 32'd0);
    icache_enable = 1'b0;
    @(posedge clk); #1 rst = 1'b0;

    // Valid bits were cleared: a previously cached line misses again
    fetch_miss(32'h0000_0000, 32'h0000_0513, 1);

    repeat (3) @(posedge clk);
    check("sb_empty", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
